// File: rtl/c1_pixel_streamer.sv
// -----------------------------------------------------------------------------
// c1_pixel_streamer
//
// Purpose:
//   Transmit-side pixel source for the C1 convolution front end. On a start
//   pulse it reads one IMG_W x IMG_H image of signed 8-bit pixels, in raster
//   order, from a synchronous-read image memory. It streams the pixels to the
//   C1 layer over a valid/ready handshake at up to one pixel per clock. When
//   the last pixel has been accepted it signals completion to the top-level
//   sequencer.
//
//   Pixels are staged in a 2-entry output FIFO. Reads are only issued when
//   the FIFO is guaranteed to have room for the returning data. That makes
//   backpressure lossless and still allows a gap-free stream when the
//   consumer is always ready.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   i_start         start request, only honoured while idle
//   i_abort         synchronous abort; returns to idle and flushes the FIFO
//   o_busy          high from start acceptance until the last pixel is taken
//   o_done          one-cycle pulse after the final pixel handshake
//   mem_rd_en       image memory read strobe
//   mem_addr        image memory read address (row*IMG_W+col)
//   mem_rd_data     image memory read data, valid one cycle after mem_rd_en
//   pixel_in_valid  pixel available to the C1 layer
//   pixel_in        pixel value (signed 8-bit, passed through bit-exact)
//   pixel_ready     C1 layer accepts the pixel this cycle
//   o_pix_cnt       number of pixels accepted since start (debug)
// -----------------------------------------------------------------------------
module c1_pixel_streamer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              pixel_in_valid,
    output logic signed [7:0] pixel_in,
    input  logic              pixel_ready,
    output logic [ADDR_W:0]   o_pix_cnt
);

    localparam int NUM_PIX = IMG_W * IMG_H;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(NUM_PIX - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   pix_cnt_q;
    logic              inflight_q;

    logic [1:0]        fifo_cnt_q;
    logic signed [7:0] fifo_head_q;
    logic signed [7:0] fifo_tail_q;

    logic start_accept;
    logic pop;
    logic push;
    logic last_issue;
    logic last_xfer;
    logic [2:0] occupancy;
    logic [2:0] room_limit;

    // A start is only taken while idle, and an abort in the same cycle wins.
    assign start_accept = (state_q == IDLE) && i_start && !i_abort;

    // A handshake completes on any edge where valid and ready are both high.
    assign pop = pixel_in_valid && pixel_ready;

    // Read data lands one cycle after its strobe. Clearing inflight_q on
    // abort is what throws away a response that is still in flight.
    assign push = inflight_q;

    assign last_issue = mem_rd_en && (addr_q == LAST_ADDR);
    assign last_xfer  = pop && (pix_cnt_q == LAST_CNT);

    // Issue a read only if the entries already held plus the one in flight,
    // minus the one leaving this cycle, leave a free slot. Written as
    // count + inflight < 2 + pop to avoid an unsigned underflow.
    assign occupancy  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign room_limit = 3'd2 + {2'b00, pop};

    // Reads are issued only while the frame still has addresses to fetch.
    // The rule looks at pixel_ready, but valid is taken only from
    // registered FIFO state, so valid never depends on ready.
    always_comb begin
        mem_rd_en = 1'b0;
        if (state_q == RUN) begin
            mem_rd_en = (occupancy < room_limit);
        end
    end

    // State register; reset and abort both return the sequencer to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RUN fetches addresses, DRAIN waits for the buffered
    // and in-flight pixels to be taken, and DONE lasts one cycle so that it
    // can act as the completion pulse. Abort overrides every other event.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (i_abort) begin
            state_d = IDLE;
        end
    end

    // Address counter, accepted-pixel counter and read-in-flight flag.
    // The address stops at the last pixel instead of moving past the frame.
    // The pixel count is kept after completion so it can be read while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            pix_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else if (i_abort) begin
            pix_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else if (start_accept) begin
            addr_q     <= '0;
            pix_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= mem_rd_en;
            if (mem_rd_en && (addr_q != LAST_ADDR)) begin
                addr_q <= addr_q + ADDR_ONE;
            end
            if (pop) begin
                pix_cnt_q <= pix_cnt_q + CNT_ONE;
            end
        end
    end

    // Two-entry output FIFO. The head register drives pixel_in directly and
    // only changes on a pop or on a push into an empty FIFO. This keeps the
    // presented pixel stable for as long as the consumer stalls. A push
    // into a full FIFO cannot happen because of the read issue rule.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_cnt_q  <= 2'd0;
            fifo_head_q <= '0;
            fifo_tail_q <= '0;
        end else if (i_abort || start_accept) begin
            fifo_cnt_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (fifo_cnt_q == 2'd0) begin
                        fifo_head_q <= $signed(mem_rd_data);
                    end else begin
                        fifo_tail_q <= $signed(mem_rd_data);
                    end
                    fifo_cnt_q <= fifo_cnt_q + 2'd1;
                end
                2'b01: begin
                    fifo_head_q <= fifo_tail_q;
                    fifo_cnt_q  <= fifo_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_q == 2'd1) begin
                        fifo_head_q <= $signed(mem_rd_data);
                    end else begin
                        fifo_head_q <= fifo_tail_q;
                        fifo_tail_q <= $signed(mem_rd_data);
                    end
                end
                default: begin
                    fifo_cnt_q <= fifo_cnt_q;
                end
            endcase
        end
    end

    // Status outputs are decoded from registered state only. o_done is high
    // in the single DONE cycle that follows the final handshake.
    assign o_busy         = (state_q == RUN) || (state_q == DRAIN);
    assign o_done         = (state_q == DONE);
    assign mem_addr       = addr_q;
    assign pixel_in_valid = (fifo_cnt_q != 2'd0);
    assign pixel_in       = fifo_head_q;
    assign o_pix_cnt      = pix_cnt_q;

endmodule

// File: tb/tb_c1_pixel_streamer.sv
// -----------------------------------------------------------------------------
// tb_c1_pixel_streamer
//
// Purpose:
//   Self-checking bench for c1_pixel_streamer. A full-size 32x32 instance
//   and a 4x4 instance are each fed by a synchronous-read memory model whose
//   content is addr[7:0]. A free-running monitor models FIFO occupancy,
//   pixel order and hold-while-stalled behaviour. Directed sequences cover
//   start latency, backpressure, abort, asynchronous reset and the small
//   image.
// -----------------------------------------------------------------------------
module tb_c1_pixel_streamer;

    logic        clk;
    logic        reset;

    // Full-size instance
    logic        i_start;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_rd_data;
    logic        pixel_in_valid;
    logic [7:0]  pixel_in;
    logic        pixel_ready;
    logic [10:0] o_pix_cnt;

    // 4x4 instance
    logic        s_start;
    logic        s_abort;
    logic        s_busy;
    logic        s_done;
    logic        s_rd_en;
    logic [9:0]  s_addr;
    logic [7:0]  s_rd_data;
    logic        s_valid;
    logic [7:0]  s_pix;
    logic        s_ready;
    logic [10:0] s_cnt;

    int total;
    int bad;

    // Monitor model state
    int          exp_pix;
    int          occ;
    int          xfers;
    bit          infl;
    bit          hold;
    logic [7:0]  held;

    typedef struct {
        logic       start;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_pix;
        logic       exp_rd_en;
        logic [9:0] exp_addr;
        logic       exp_busy;
        logic [10:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    c1_pixel_streamer #(
        .IMG_W  (32),
        .IMG_H  (32),
        .ADDR_W (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in       (pixel_in),
        .pixel_ready    (pixel_ready),
        .o_pix_cnt      (o_pix_cnt)
    );

    c1_pixel_streamer #(
        .IMG_W  (4),
        .IMG_H  (4),
        .ADDR_W (10)
    ) dut_small (
        .clk            (clk),
        .reset          (reset),
        .i_start        (s_start),
        .i_abort        (s_abort),
        .o_busy         (s_busy),
        .o_done         (s_done),
        .mem_rd_en      (s_rd_en),
        .mem_addr       (s_addr),
        .mem_rd_data    (s_rd_data),
        .pixel_in_valid (s_valid),
        .pixel_in       (s_pix),
        .pixel_ready    (s_ready),
        .o_pix_cnt      (s_cnt)
    );

    // Clock: period 10, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read image memories holding addr[7:0]
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem_addr[7:0];
        end
        if (s_rd_en) begin
            s_rd_data <= s_addr[7:0];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic rd);
        @(negedge clk);
        i_start     = st;
        i_abort     = ab;
        pixel_ready = rd;
    endtask

    // Stream with ready high until the accepted count reaches target; the
    // loop stops on the negedge where that count is first visible.
    task automatic streamUntil(input int target, input int limit);
        bit reached;
        reached = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (32'(o_pix_cnt) == target) begin
                reached = 1'b1;
                break;
            end
            i_start     = 1'b0;
            i_abort     = 1'b0;
            pixel_ready = 1'b1;
        end
        checkOutput("reach_pixel_count", 32'(reached), 32'd1);
    endtask

    // Run the current frame to its o_done pulse (ready high or toggling)
    task automatic finishFrame(input bit toggle, input int limit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            applyStimulus(1'b0, 1'b0, toggle ? ((k % 2) == 0) : 1'b1);
            #1;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("frame_done_seen", 32'(seen), 32'd1);
        checkOutput("frame_pix_cnt", 32'(o_pix_cnt), 32'd1024);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: samples 3 time units after each negedge, i.e. with the inputs
    // for the coming edge already applied. Checks pixel order, stability
    // while stalled and that the buffered plus returning data never exceeds
    // two entries.
    initial begin
        exp_pix = 0;
        occ     = 0;
        xfers   = 0;
        infl    = 1'b0;
        hold    = 1'b0;
        held    = 8'd0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                occ     = 0;
                infl    = 1'b0;
                hold    = 1'b0;
                exp_pix = 0;
            end else begin
                bit pop;
                pop = pixel_in_valid && pixel_ready;
                checkOutput("mon_valid_vs_model", 32'(pixel_in_valid), 32'(occ != 0));
                if (hold) begin
                    checkOutput("mon_hold_valid", 32'(pixel_in_valid), 32'd1);
                    checkOutput("mon_hold_data", 32'(pixel_in), 32'(held));
                end
                if (pop) begin
                    checkOutput("mon_pixel_order", 32'(pixel_in), 32'(exp_pix % 256));
                    exp_pix++;
                    xfers++;
                end
                hold = pixel_in_valid && !pixel_ready;
                held = pixel_in;
                if (i_abort) begin
                    occ  = 0;
                    infl = 1'b0;
                    hold = 1'b0;
                end else if (i_start && !o_busy && !o_done) begin
                    exp_pix = 0;
                    occ     = 0;
                    infl    = 1'b0;
                end else begin
                    occ = occ + (infl ? 1 : 0) - (pop ? 1 : 0);
                    checkOutput("mon_occupancy_le2", 32'(occ <= 2), 32'd1);
                    infl = mem_rd_en;
                end
            end
        end
    end

    initial begin
        int dones;
        int sx;
        int max_addr;

        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        pixel_ready = 1'b0;
        mem_rd_data = 8'd0;
        s_start     = 1'b0;
        s_abort     = 1'b0;
        s_ready     = 1'b1;
        s_rd_data   = 8'd0;

        // start/ready in, then valid, pixel, rd_en, addr, busy, pix_cnt
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 10'd0, 1'b0, 11'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 10'd0, 1'b1, 11'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 10'd1, 1'b1, 11'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 10'd2, 1'b1, 11'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 10'd3, 1'b1, 11'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 10'd3, 1'b1, 11'd1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 10'd3, 1'b1, 11'd1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 10'd4, 1'b1, 11'd2};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 10'd5, 1'b1, 11'd3};

        repeat (2) @(negedge clk);
        #1;
        checkOutput("small_reset_busy", 32'(s_busy), 32'd0);
        checkOutput("small_reset_valid", 32'(s_valid), 32'd0);
        checkOutput("small_reset_rd_en", 32'(s_rd_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table: reset state, start latency and a two-cycle stall
        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].start, 1'b0, vecs[i].ready);
            #1;
            checkOutput($sformatf("vec%0d_valid", i), 32'(pixel_in_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_pixel", i), 32'(pixel_in), 32'(vecs[i].exp_pix));
            checkOutput($sformatf("vec%0d_rd_en", i), 32'(mem_rd_en), 32'(vecs[i].exp_rd_en));
            checkOutput($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_pix_cnt", i), 32'(o_pix_cnt), 32'(vecs[i].exp_cnt));
            checkOutput($sformatf("vec%0d_done", i), 32'(o_done), 32'd0);
        end
        finishFrame(1'b0, 2000);

        // Full-rate frame: transfers on E3..E1026, o_done after E1026
        $display("[TB] full-rate frame");
        dones = 0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 1030; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            #1;
            if (o_done) begin
                dones++;
            end
            if (k == 1026) begin
                checkOutput("t1_done_before_last", 32'(o_done), 32'd0);
                checkOutput("t1_busy_before_last", 32'(o_busy), 32'd1);
                checkOutput("t1_cnt_before_last", 32'(o_pix_cnt), 32'd1023);
            end
            if (k == 1027) begin
                checkOutput("t1_done_after_last", 32'(o_done), 32'd1);
                checkOutput("t1_busy_after_last", 32'(o_busy), 32'd0);
                checkOutput("t1_cnt_after_last", 32'(o_pix_cnt), 32'd1024);
            end
            if (k == 1028) begin
                checkOutput("t1_done_one_cycle", 32'(o_done), 32'd0);
                checkOutput("t1_cnt_holds_idle", 32'(o_pix_cnt), 32'd1024);
            end
        end
        checkOutput("t1_done_pulses", 32'(dones), 32'd1);

        // Toggling ready: order and count intact
        $display("[TB] toggling ready");
        applyStimulus(1'b1, 1'b0, 1'b1);
        xfers = 0;
        finishFrame(1'b1, 4000);
        checkOutput("t2_transfers", 32'(xfers), 32'd1024);

        // 50-cycle stall at pixel 100: two buffered, no further reads
        $display("[TB] long stall");
        applyStimulus(1'b1, 1'b0, 1'b1);
        streamUntil(100, 300);
        pixel_ready = 1'b0;
        repeat (50) applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t3_valid", 32'(pixel_in_valid), 32'd1);
        checkOutput("t3_head_pixel", 32'(pixel_in), 32'd100);
        checkOutput("t3_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("t3_addr", 32'(mem_addr), 32'd102);
        checkOutput("t3_pix_cnt", 32'(o_pix_cnt), 32'd100);
        finishFrame(1'b0, 2000);

        // Abort at pixel 500, then a clean restart from address 0
        $display("[TB] abort");
        applyStimulus(1'b1, 1'b0, 1'b1);
        streamUntil(500, 800);
        i_abort = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("t4_valid_after_abort", 32'(pixel_in_valid), 32'd0);
        checkOutput("t4_busy_after_abort", 32'(o_busy), 32'd0);
        checkOutput("t4_cnt_after_abort", 32'(o_pix_cnt), 32'd0);
        checkOutput("t4_rd_en_after_abort", 32'(mem_rd_en), 32'd0);
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            #1;
            if (o_done || pixel_in_valid) begin
                dones++;
            end
        end
        checkOutput("t4_quiet_after_abort", 32'(dones), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("t4_restart_rd_en", 32'(mem_rd_en), 32'd1);
        checkOutput("t4_restart_addr", 32'(mem_addr), 32'd0);
        finishFrame(1'b0, 2000);

        // Asynchronous reset between edges, then start ignored during RUN
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0, 1'b1);
        streamUntil(200, 400);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("t5_rst_done", 32'(o_done), 32'd0);
        checkOutput("t5_rst_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("t5_rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("t5_rst_valid", 32'(pixel_in_valid), 32'd0);
        checkOutput("t5_rst_pixel", 32'(pixel_in), 32'd0);
        checkOutput("t5_rst_pix_cnt", 32'(o_pix_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        streamUntil(10, 100);
        i_start = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("t5_restart_ignored_cnt", 32'(o_pix_cnt), 32'd11);
        checkOutput("t5_restart_ignored_addr", 32'(mem_addr), 32'd13);
        checkOutput("t5_restart_ignored_busy", 32'(o_busy), 32'd1);
        finishFrame(1'b0, 2000);

        // 4x4 image: 16 transfers, o_done after E18, address capped at 15
        $display("[TB] 4x4 image");
        dones    = 0;
        sx       = 0;
        max_addr = 0;
        @(negedge clk);
        s_start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            s_start = 1'b0;
            #1;
            if (s_valid && s_ready) begin
                checkOutput("t6_pixel", 32'(s_pix), 32'(sx));
                sx++;
            end
            if (s_done) begin
                dones++;
                checkOutput("t6_done_cycle", 32'(k), 32'd19);
            end
            if (32'(s_addr) > max_addr) begin
                max_addr = 32'(s_addr);
            end
        end
        checkOutput("t6_transfers", 32'(sx), 32'd16);
        checkOutput("t6_done_pulses", 32'(dones), 32'd1);
        checkOutput("t6_max_addr", 32'(max_addr), 32'd15);
        checkOutput("t6_pix_cnt", 32'(s_cnt), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c1_pixel_streamer.md
Name: c1_pixel_streamer

Overview:
- Transmit-side source for the C1 front end's pixel input handshake: pixel_in_valid, pixel_in, pixel_ready.
- On a start pulse it reads one IMG_W x IMG_H signed 8-bit image, in raster order, from a synchronous-read image memory.
- It streams the pixels into the C1 layer at up to one pixel per clock, with full valid/ready backpressure.
- It sits between the image buffer and the C1 convolution layer and signals completion to the top-level sequencer.

Parameters:
IMG_W, 32, image width in pixels
IMG_H, 32, image height in pixels
ADDR_W, 10, image memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
i_start  input  1  start request; sampled only in IDLE
i_abort  input  1  synchronous abort; returns to IDLE and flushes the buffer
o_busy  output  1  high from the edge i_start is accepted until the last pixel is accepted
o_done  output  1  one-cycle pulse after the final pixel handshake
mem_rd_en  output  1  image memory read strobe
mem_addr  output  ADDR_W  read address, raster index row*IMG_W+col
mem_rd_data  input  8  read data, valid exactly one cycle after mem_rd_en
pixel_in_valid  output  1  pixel available to the C1 layer
pixel_in  output  8 (signed)  pixel value
pixel_ready  input  1  C1 layer accepts the pixel this cycle
o_pix_cnt  output  ADDR_W+1  number of pixels accepted since start (debug)

Behaviour:
- Reset (asynchronous, any time):
  - state = IDLE; all counters and buffer cleared.
  - o_busy = 0, o_done = 0, mem_rd_en = 0, mem_addr = 0.
  - pixel_in_valid = 0, pixel_in = 0, o_pix_cnt = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN: i_start=1 and i_abort=0 at edge E0.
  - RUN -> DRAIN: edge at which the last address (IMG_W*IMG_H-1) is issued.
  - DRAIN -> DONE: edge at which the last pixel handshake occurs.
  - DONE -> IDLE: unconditionally on the next edge.
  - Any state except IDLE -> IDLE: i_abort=1 (i_abort has priority over all other events).
  - i_start is ignored outside IDLE.
- Handshake: a transfer occurs on an edge where pixel_in_valid && pixel_ready.
  - Once pixel_in_valid is asserted, pixel_in_valid and pixel_in must hold stable until the transfer.
  - pixel_in_valid never depends combinationally on pixel_ready.
- Output buffer: 2-entry FIFO; pixel_in is the head entry and pixel_in_valid = (count != 0).
  - Read issue rule: in RUN, assert mem_rd_en when count + inflight - pop < 2.
    - inflight = mem_rd_en of the previous cycle.
    - pop = the transfer this cycle.
  - This rule guarantees no overflow and no bubbles when pixel_ready is held high.
  - mem_rd_data is written into the FIFO on the edge after its read.
  - Simultaneous push and pop is legal; count is unchanged.
- Address counter: increments on each issued read; no wrap within a frame; reset to 0 on start.
- Latency:
  - mem_rd_en is high in the cycle after E0, with mem_addr = 0.
  - pixel_in_valid rises at E2.
  - With pixel_ready held high, transfers occur at E3 .. E(2+N), N = IMG_W*IMG_H, i.e. one per cycle with no gaps.
- o_done: registered; high for exactly the one cycle following the edge of the N-th transfer.
  - o_busy falls at that same edge.
- o_pix_cnt: increments on each transfer; cleared on start and on abort; holds its value in IDLE after completion.
- Abort:
  - FIFO cleared, pixel_in_valid deasserted at the abort edge.
  - An in-flight read response in the next cycle is discarded.
  - No o_done pulse.
- Backpressure (pixel_ready=0 for any duration): FIFO fills to 2 and reads stop; no data is lost or duplicated.
- Arithmetic: pixel data passes through bit-exact; no sign extension or saturation.

Test Plan:
- Memory holds the byte addr[7:0], pixel_ready tied 1, pulse i_start -> 1024 transfers on consecutive edges E3..E1026 with values 0x00,0x01,..,0xFF repeating; o_done high for one cycle after E1026; o_pix_cnt=1024.
- Same image with pixel_ready toggling 1,0,1,0 -> 1024 transfers, order intact; pixel_in stable while valid&&!ready; mem_rd_en never issued when count+inflight would exceed 2.
- pixel_ready held 0 for 50 cycles at pixel 100 -> exactly 2 pixels buffered; resumed stream continues 100,101,102.. with no gap or repeat.
- i_abort at pixel 500 -> pixel_in_valid=0 next cycle; no o_done pulse; state IDLE; a new i_start restarts from address 0 with pixel value 0x00.
- Asynchronous reset asserted mid-frame between clock edges -> all outputs 0 immediately; i_start re-pulsed during RUN is ignored.
- IMG_W=IMG_H=4 parameter override -> 16 transfers, o_done after the 16th transfer, mem_addr never exceeds 15.
